// File: rtl/wb_pkg.sv
// Shared encodings and history-entry layout for the writeback stage.
// History fields are sized for the widest supported build; narrower builds zero-extend.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2,
    WB_IMM  = 2'd3
  } wbSel_t;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ldSize_t;

  localparam int HIST_ADDR_MAX_W = 8;
  localparam int HIST_DATA_MAX_W = 128;

  typedef struct packed {
    logic                       valid;
    logic [HIST_ADDR_MAX_W-1:0] addr;
    logic [HIST_DATA_MAX_W-1:0] data;
  } histEntry_t;

endpackage

// File: rtl/wb_load_align.sv
// Sub-word load alignment: shift by byte offset, keep the selected size, then zero/sign extend.
// The offset is forced to the natural alignment of the size; word size on a narrow datapath acts as full width.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] memRdata,
  input  logic [1:0]        ldSize,
  input  logic              ldSigned,
  input  logic [OFF_W-1:0]  ldOffset,
  output logic [DATA_W-1:0] loadData
);

  localparam int WORD_W = (DATA_W < 32) ? DATA_W : 32;
  localparam logic [DATA_W-1:0] MASK_B = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] MASK_H = DATA_W'(16'hFFFF);
  localparam logic [DATA_W-1:0] MASK_W = DATA_W'(32'hFFFF_FFFF);

  logic [OFF_W-1:0]  effOffset;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keepMask;
  logic              signBit;

  always_comb begin
    effOffset = ldOffset;
    keepMask  = '1;
    signBit   = 1'b0;
    case (ldSize_t'(ldSize))
      LD_B: begin
        keepMask = MASK_B;
      end
      LD_H: begin
        effOffset[0] = 1'b0;
        keepMask     = MASK_H;
      end
      LD_W: begin
        effOffset = ldOffset & ~OFF_W'(3);
        keepMask  = MASK_W;
      end
      default: begin
        effOffset = '0;
        keepMask  = '1;
      end
    endcase

    shifted = memRdata >> {effOffset, 3'b000};

    case (ldSize_t'(ldSize))
      LD_B:    signBit = shifted[7];
      LD_H:    signBit = shifted[15];
      LD_W:    signBit = shifted[WORD_W-1];
      default: signBit = shifted[DATA_W-1];
    endcase

    loadData = (shifted & keepMask) | ((ldSigned && signBit) ? ~keepMask : '0);
  end

endmodule

// File: rtl/wb_stage_param.sv
// Parametrised writeback stage: four-source select, registered register-file write and bypass history.
// Optional retire counter enabled by defining WB_RETIRE_COUNTER_EN.
module wb_stage_param
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int HIST_DEPTH = 2,
  localparam int OFF_W     = $clog2(DATA_W/8)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_rdata,
  input  logic [DATA_W-1:0]     in_link,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [1:0]            in_wb_sel,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_signed,
  input  logic [OFF_W-1:0]      in_ld_offset,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  out_valid,
  input  logic [REG_ADDR_W-1:0] query_addr,
  output logic                  query_hit,
  output logic [DATA_W-1:0]     query_data
`ifdef WB_RETIRE_COUNTER_EN
  ,
  output logic [31:0]           retire_count
`endif
);

  logic              cap;
  logic              weNext;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] wdataNext;
  logic              unusedHistBits;
  histEntry_t        hist [HIST_DEPTH];

  assign cap    = in_valid & ~flush_i;
  assign weNext = cap & in_reg_write & (in_rd != '0);

  wb_load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) uLoadAlign (
    .memRdata (in_mem_rdata),
    .ldSize   (in_ld_size),
    .ldSigned (in_ld_signed),
    .ldOffset (in_ld_offset),
    .loadData (loadData)
  );

  always_comb begin
    wdataNext = in_alu_result;
    case (wbSel_t'(in_wb_sel))
      WB_LOAD: wdataNext = loadData;
      WB_LINK: wdataNext = in_link;
      WB_IMM:  wdataNext = in_imm;
      default: wdataNext = in_alu_result;
    endcase
  end

  // Address and data hold across bubbles so the register file sees stable values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      out_valid <= 1'b0;
    end else begin
      rf_we     <= weNext;
      out_valid <= cap;
      if (cap) begin
        rf_waddr <= in_rd;
        rf_wdata <= wdataNext;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist[i] <= '0;
      end
    end else if (weNext) begin
      hist[0] <= '{valid: 1'b1,
                   addr:  HIST_ADDR_MAX_W'(in_rd),
                   data:  HIST_DATA_MAX_W'(wdataNext)};
      for (int i = 1; i < HIST_DEPTH; i++) begin
        hist[i] <= hist[i-1];
      end
    end
  end

  // Scan oldest to newest so the newest matching entry is the one left standing.
  always_comb begin
    query_hit      = 1'b0;
    query_data     = '0;
    unusedHistBits = 1'b0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      unusedHistBits = unusedHistBits ^ (^hist[i].data);
      if (hist[i].valid && (query_addr != '0) &&
          (hist[i].addr == HIST_ADDR_MAX_W'(query_addr))) begin
        query_hit  = 1'b1;
        query_data = hist[i].data[DATA_W-1:0];
      end
    end
  end

`ifdef WB_RETIRE_COUNTER_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retire_count <= '0;
    end else if (cap) begin
      retire_count <= retire_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_param.sv
// Directed self-checking bench for wb_stage_param (DATA_W=32, HIST_DEPTH=2).
// Counter checks are compiled only when WB_RETIRE_COUNTER_EN is defined.
module tb_wb_stage_param;

  logic        clock;
  logic        reset;
  logic        flush_i;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_rdata;
  logic [31:0] in_link;
  logic [31:0] in_imm;
  logic [1:0]  in_wb_sel;
  logic [1:0]  in_ld_size;
  logic        in_ld_signed;
  logic [1:0]  in_ld_offset;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        out_valid;
  logic [4:0]  query_addr;
  logic        query_hit;
  logic [31:0] query_data;
`ifdef WB_RETIRE_COUNTER_EN
  logic [31:0] retire_count;
`endif

  int checks = 0;
  int errors = 0;

  wb_stage_param #(
    .DATA_W     (32),
    .REG_ADDR_W (5),
    .HIST_DEPTH (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .flush_i       (flush_i),
    .in_valid      (in_valid),
    .in_alu_result (in_alu_result),
    .in_mem_rdata  (in_mem_rdata),
    .in_link       (in_link),
    .in_imm        (in_imm),
    .in_wb_sel     (in_wb_sel),
    .in_ld_size    (in_ld_size),
    .in_ld_signed  (in_ld_signed),
    .in_ld_offset  (in_ld_offset),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .out_valid     (out_valid),
    .query_addr    (query_addr),
    .query_hit     (query_hit),
    .query_data    (query_data)
`ifdef WB_RETIRE_COUNTER_EN
    ,
    .retire_count  (retire_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one MEM/WB slot, then returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic valid, input logic flush, input logic [1:0] sel,
                               input logic [4:0] rd, input logic regWrite, input logic [31:0] alu,
                               input logic [31:0] rdata, input logic [1:0] size,
                               input logic sgn, input logic [1:0] off);
    in_valid      = valid;
    flush_i       = flush;
    in_wb_sel     = sel;
    in_rd         = rd;
    in_reg_write  = regWrite;
    in_alu_result = alu;
    in_mem_rdata  = rdata;
    in_ld_size    = size;
    in_ld_signed  = sgn;
    in_ld_offset  = off;
    @(posedge clock);
    #1;
  endtask

  task automatic checkQuery(input string tag, input logic [4:0] addr, input logic hit, input logic [31:0] data);
    query_addr = addr;
    #1;
    checkOutput({tag, "_hit"}, 64'(query_hit), 64'(hit));
    checkOutput({tag, "_data"}, 64'(query_data), 64'(data));
  endtask

  task automatic applyLoad(input string tag, input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [1:0] size, input logic sgn, input logic [1:0] off,
                           input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, 2'd1, rd, 1'b1, 32'h0, rdata, size, sgn, off);
    checkOutput(tag, 64'(rf_wdata), 64'(expected));
  endtask

  initial begin
    reset = 1'b1;
    flush_i = 1'b0; in_valid = 1'b0; in_alu_result = '0; in_mem_rdata = '0;
    in_link = 32'h0000_1004; in_imm = 32'hABCD_0000;
    in_wb_sel = '0; in_ld_size = '0; in_ld_signed = 1'b0; in_ld_offset = '0;
    in_rd = '0; in_reg_write = 1'b0; query_addr = 5'd5;
    #2;
    checkOutput("rst_rf_we", 64'(rf_we), 64'd0);
    checkOutput("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    checkOutput("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_query_hit", 64'(query_hit), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Load alignment and source select.
    applyLoad("ld_b_s_off3", 5'd8, 32'h80FF_7F01, 2'd0, 1'b1, 2'd3, 32'hFFFF_FF80);
    checkOutput("ld_b_s_we", 64'(rf_we), 64'd1);
    checkOutput("ld_b_s_waddr", 64'(rf_waddr), 64'd8);
    applyLoad("ld_b_u_off3", 5'd9, 32'h80FF_7F01, 2'd0, 1'b0, 2'd3, 32'h0000_0080);
    applyLoad("ld_b_u_off1", 5'd9, 32'h80FF_7F01, 2'd0, 1'b0, 2'd1, 32'h0000_007F);
    applyLoad("ld_b_s_off2", 5'd9, 32'h80FF_7F01, 2'd0, 1'b1, 2'd2, 32'hFFFF_FFFF);
    applyLoad("ld_h_s_off2", 5'd10, 32'h8000_1234, 2'd1, 1'b1, 2'd2, 32'hFFFF_8000);
    applyLoad("ld_h_u_off3", 5'd10, 32'h8000_1234, 2'd1, 1'b0, 2'd3, 32'h0000_8000);
    applyLoad("ld_h_s_off0", 5'd10, 32'h8000_F234, 2'd1, 1'b1, 2'd0, 32'hFFFF_F234);
    applyLoad("ld_w_off1", 5'd11, 32'h8000_1234, 2'd2, 1'b1, 2'd1, 32'h8000_1234);
    applyLoad("ld_d_off3", 5'd11, 32'h80FF_7F01, 2'd3, 1'b0, 2'd3, 32'h80FF_7F01);
    applyStimulus(1'b1, 1'b0, 2'd2, 5'd1, 1'b1, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    checkOutput("sel_link", 64'(rf_wdata), 64'h0000_1004);
    applyStimulus(1'b1, 1'b0, 2'd3, 5'd2, 1'b1, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    checkOutput("sel_imm", 64'(rf_wdata), 64'hABCD_0000);

    // Newest matching history entry wins.
    applyStimulus(1'b1, 1'b0, 2'd0, 5'd5, 1'b1, 32'hA, 32'h0, 2'd0, 1'b0, 2'd0);
    checkOutput("alu_r5a", 64'(rf_wdata), 64'hA);
    checkQuery("q_r5_first", 5'd5, 1'b1, 32'hA);
    applyStimulus(1'b1, 1'b0, 2'd0, 5'd5, 1'b1, 32'hB, 32'h0, 2'd0, 1'b0, 2'd0);
    checkQuery("q_r5_newest", 5'd5, 1'b1, 32'hB);
    checkQuery("q_r6_absent", 5'd6, 1'b0, 32'h0);

    // Flush kills the slot even with in_valid set.
    applyStimulus(1'b1, 1'b1, 2'd0, 5'd7, 1'b1, 32'h11, 32'h0, 2'd0, 1'b0, 2'd0);
    checkOutput("flush_we", 64'(rf_we), 64'd0);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_waddr_hold", 64'(rf_waddr), 64'd5);
    checkOutput("flush_wdata_hold", 64'(rf_wdata), 64'hB);
    checkQuery("flush_q_r7", 5'd7, 1'b0, 32'h0);
    checkQuery("flush_q_r5", 5'd5, 1'b1, 32'hB);

    // Two r6 writes push both r5 entries out.
    applyStimulus(1'b1, 1'b0, 2'd0, 5'd6, 1'b1, 32'h1, 32'h0, 2'd0, 1'b0, 2'd0);
    checkQuery("evict1_q_r5", 5'd5, 1'b1, 32'hB);
    applyStimulus(1'b1, 1'b0, 2'd0, 5'd6, 1'b1, 32'h2, 32'h0, 2'd0, 1'b0, 2'd0);
    checkQuery("evict2_q_r5", 5'd5, 1'b0, 32'h0);
    checkQuery("evict2_q_r6", 5'd6, 1'b1, 32'h2);

    // rd=0 retires without writing or pushing.
    applyStimulus(1'b1, 1'b0, 2'd0, 5'd0, 1'b1, 32'h99, 32'h0, 2'd0, 1'b0, 2'd0);
    checkOutput("r0_we", 64'(rf_we), 64'd0);
    checkOutput("r0_out_valid", 64'(out_valid), 64'd1);
    checkOutput("r0_wdata", 64'(rf_wdata), 64'h99);
    checkQuery("r0_query_zero", 5'd0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'd0, 5'd7, 1'b1, 32'h77, 32'h0, 2'd0, 1'b0, 2'd0);
    checkQuery("r0_nopush_q_r6", 5'd6, 1'b1, 32'h2);
    checkQuery("r0_nopush_q_r7", 5'd7, 1'b1, 32'h77);

    // Non-writing retire, then a bubble.
    applyStimulus(1'b1, 1'b0, 2'd0, 5'd12, 1'b0, 32'h33, 32'h0, 2'd0, 1'b0, 2'd0);
    checkOutput("nowr_we", 64'(rf_we), 64'd0);
    checkOutput("nowr_out_valid", 64'(out_valid), 64'd1);
    checkQuery("nowr_q_r12", 5'd12, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 2'd0, 5'd13, 1'b1, 32'h44, 32'h0, 2'd0, 1'b0, 2'd0);
    checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
    checkOutput("idle_waddr_hold", 64'(rf_waddr), 64'd12);

    // Asynchronous reset while a write is being presented.
    applyStimulus(1'b1, 1'b0, 2'd0, 5'd9, 1'b1, 32'h55, 32'h0, 2'd0, 1'b0, 2'd0);
    checkOutput("pre_rst_we", 64'(rf_we), 64'd1);
    query_addr = 5'd9;
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_we", 64'(rf_we), 64'd0);
    checkOutput("mid_rst_waddr", 64'(rf_waddr), 64'd0);
    checkOutput("mid_rst_wdata", 64'(rf_wdata), 64'd0);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_query_hit", 64'(query_hit), 64'd0);
    @(negedge clock);
    reset = 1'b0;

`ifdef WB_RETIRE_COUNTER_EN
    checkOutput("cnt_reset", 64'(retire_count), 64'd0);
    force dut.retire_count = 32'hFFFF_FFFE;
    #1;
    release dut.retire_count;
    applyStimulus(1'b1, 1'b0, 2'd0, 5'd3, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    checkOutput("cnt_ffffffff", 64'(retire_count), 64'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 2'd0, 5'd3, 1'b1, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    checkOutput("cnt_wrap", 64'(retire_count), 64'd0);
    applyStimulus(1'b1, 1'b1, 2'd0, 5'd3, 1'b1, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    checkOutput("cnt_flush_hold", 64'(retire_count), 64'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, 5'd0, 1'b1, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    checkOutput("cnt_end", 64'(retire_count), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/wb_stage_param.md
Name: wb_stage_param

Overview:
- Parametrised writeback stage, successor to the fixed 32-bit two-source writeback block.
- Selects the register-file write data from four sources (ALU, load, link, immediate).
- Aligns and extends sub-word loads, then registers the write (rd, we, data) for the register file.
- Keeps a small history of recent committed writes so decode can bypass register-file read-after-write.

Parameters:
- DATA_W, 32, datapath width; multiple of 8, >= 16.
- REG_ADDR_W, 5, register address width.
- HIST_DEPTH, 2, number of committed writes retained for bypass lookup; >= 1.
- OFF_W, $clog2(DATA_W/8), byte-offset width (derived localparam).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush_i  in  1  kill the instruction presented this cycle
- in_valid  in  1  MEM/WB slot holds an instruction
- in_alu_result  in  DATA_W  ALU result
- in_mem_rdata  in  DATA_W  raw memory read word
- in_link  in  DATA_W  return address (PC+4)
- in_imm  in  DATA_W  upper-immediate value
- in_wb_sel  in  2  source: 0 ALU, 1 load, 2 link, 3 imm
- in_ld_size  in  2  0 byte, 1 half, 2 word, 3 full DATA_W
- in_ld_signed  in  1  sign-extend load when 1
- in_ld_offset  in  OFF_W  byte offset of load within word
- in_rd  in  REG_ADDR_W  destination register
- in_reg_write  in  1  instruction writes rd
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- out_valid  out  1  an instruction retired this cycle
- query_addr  in  REG_ADDR_W  bypass lookup address from decode
- query_hit  out  1  lookup matched a history entry
- query_data  out  DATA_W  newest matching data
- retire_count  out  32  retired-instruction count; present only with the macro

Behaviour:
- Reset (async, active-high): rf_we=0, rf_waddr=0, rf_wdata=0, out_valid=0, all history valid bits 0, retire_count=0.
- Latency: inputs are captured at a rising edge; rf_* and out_valid reflect them for the following cycle.
- Capture condition: cap = in_valid & ~flush_i. flush_i wins over in_valid.
- When cap=0: out_valid=0 and rf_we=0 next cycle. rf_waddr and rf_wdata hold. History is unchanged.
- rf_we = cap & in_reg_write & (in_rd != 0). Register 0 is never written.
- Load alignment when in_wb_sel=1:
  - Shift in_mem_rdata right by 8*in_ld_offset.
  - Keep 8/16/32/DATA_W bits according to in_ld_size, then zero- or sign-extend to DATA_W.
  - A size wider than DATA_W is treated as full width.
  - Offset bits that would cross the word boundary for the selected size are ignored: offset is masked to natural alignment.
- History is a shift register of {valid, addr, data}. Entry 0 always equals the current rf_* values when rf_we=1.
  - Push only on edges where a write commits (rf_we next =1); otherwise no shift.
  - The oldest entry is discarded when full.
- Query is combinational:
  - Scan entries 0..HIST_DEPTH-1; the lowest index (newest) valid match wins.
  - query_addr=0 always gives hit=0, data=0.
  - No match gives hit=0, data=0.
- Reset mid-operation: outputs and history clear immediately, without waiting for a clock edge.

Optional Feature:
- Macro: WB_RETIRE_COUNTER_EN.
- Defined: retire_count increments by 1 on every edge where cap=1, whether or not the instruction writes. It wraps 0xFFFFFFFF -> 0.
- Undefined: the port and counter are absent.

Decomposition:
- Package wb_pkg holds:
  - wb_sel encodings (WB_ALU, WB_LOAD, WB_LINK, WB_IMM).
  - ld_size encodings (LD_B, LD_H, LD_W, LD_D).
  - The history-entry struct typedef.
- One sub-module, wb_load_align: combinational shift, size mask and sign/zero extension.

Test Plan:
- Reset asserted mid-stream with rf_we=1 -> all outputs 0 and query_hit=0 immediately.
- wb_sel=1, rdata=0x80FF7F01, size=byte, signed, offset=3 -> rf_wdata=0xFFFFFF80. Same stimulus unsigned -> 0x00000080.
- wb_sel=1, rdata=0x8000_1234, size=half, signed, offset=2 -> 0xFFFF8000.
- in_valid=1, in_rd=7, alu=0x11, and flush_i=1 in the same cycle -> rf_we=0, out_valid=0, history unchanged.
- Commit writes r5=0xA then r5=0xB, with HIST_DEPTH=2 -> query r5 gives hit=1, data=0xB. A third write r6 followed by a fourth write r6 evicts both r5 entries -> query r5 gives hit=0.
- in_rd=0 with reg_write=1 -> rf_we=0 and no history push. With WB_RETIRE_COUNTER_EN, the count is preloaded near wrap and 3 retirements from 0xFFFFFFFE end at 1.
